// File: rtl/phy_tx_link_pkg.sv
// -----------------------------------------------------------------------------
// phy_tx_link_pkg
// Shared definitions for the PHY TX link sequencer: state encodings, the
// default training/idle patterns and the rx_active qualification length.
// -----------------------------------------------------------------------------
package phy_tx_link_pkg;

   // State encodings, visible on state_out.
   localparam logic [2:0] S_DISABLED = 3'd0;
   localparam logic [2:0] S_TRAIN    = 3'd1;
   localparam logic [2:0] S_WAIT_ACK = 3'd2;
   localparam logic [2:0] S_ACTIVE   = 3'd3;
   localparam logic [2:0] S_DRAIN    = 3'd4;

   typedef enum logic [2:0] {
      ST_DISABLED = S_DISABLED,
      ST_TRAIN    = S_TRAIN,
      ST_WAIT_ACK = S_WAIT_ACK,
      ST_ACTIVE   = S_ACTIVE,
      ST_DRAIN    = S_DRAIN
   } link_state_e;

   // COM on every byte lane during training, IDL on every lane when idle.
   localparam logic [31:0] TRAIN_WORD_DEFAULT = 32'hBCBCBCBC;
   localparam logic [31:0] IDLE_WORD_DEFAULT  = 32'h7C7C7C7C;

   // Consecutive rx_active samples required in WAIT_ACK before going ACTIVE.
   localparam int unsigned RX_QUAL_LEN = 2;

endpackage

// File: rtl/phy_tx_link_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// tx_hold_fifo
// Synchronous hold FIFO (DEPTH x WIDTH) buffering host words in front of the
// link sequencer. Pointers wrap modulo DEPTH (DEPTH must be a power of 2).
//
// Ports:
//   clk_i    clock (clk_2f domain)
//   reset_i  synchronous active-high reset, empties the FIFO
//   flush_i  synchronous flush, empties the FIFO (used on link loss in DRAIN)
//   push_i   write din_i (ignored when full)
//   pop_i    advance read pointer (ignored when empty)
//   din_i    write data
//   dout_o   head of FIFO (valid when !empty_o)
//   count_o  number of stored words, 0..DEPTH
//   full_o   count_o == DEPTH
//   empty_o  count_o == 0
// -----------------------------------------------------------------------------
module tx_hold_fifo #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // NOTE: non-blocking (<=) for every register so all state updates see the
   // pre-edge values, regardless of statement order inside the block.
   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         // Simultaneous push and pop leaves the count unchanged.
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and count
   // define which entries are meaningful, so the data itself needs no reset.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/phy_tx_link_ctrl.sv
// -----------------------------------------------------------------------------
// phy_tx_link_ctrl
// Link sequencer in front of the PHY TX datapath (clk_2f domain). Buffers host
// words in a hold FIFO, runs a training then idle preamble, forwards words
// while the partner is locked, and drains the FIFO on disable.
//
// Ports:
//   clk_2f        clock
//   reset         synchronous active-high reset
//   enable        host request to bring up / keep up the link
//   rx_active     partner lock indication (synchronous to clk_2f)
//   data_in       host word
//   valid_in      host word valid; push = valid_in & ready_out
//   ready_out     FIFO can accept (enable & count < DEPTH)
//   data_out      datapath data_input (registered)
//   valid_out     datapath valid (registered)
//   active_out    datapath active (registered)
//   link_up       high while in ACTIVE (registered)
//   state_out     current state encoding
//   overflow_err  sticky: valid_in seen while ready_out=0 and enable=1
// -----------------------------------------------------------------------------
module phy_tx_link_ctrl
   import phy_tx_link_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned TRAIN_WORDS = 4,
   parameter int unsigned TIMEOUT     = 64,
   parameter logic [31:0] TRAIN_WORD  = TRAIN_WORD_DEFAULT,
   parameter logic [31:0] IDLE_WORD   = IDLE_WORD_DEFAULT
) (
   input  logic        clk_2f,
   input  logic        reset,
   input  logic        enable,
   input  logic        rx_active,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic [31:0] data_out,
   output logic        valid_out,
   output logic        active_out,
   output logic        link_up,
   output logic [2:0]  state_out,
   output logic        overflow_err
);

   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned TCW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
   localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned QCW = (RX_QUAL_LEN > 1) ? $clog2(RX_QUAL_LEN) : 1;

   link_state_e   state_q, state_d;
   logic [TCW-1:0] tcnt_q, tcnt_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [QCW-1:0] qual_q, qual_d;

   logic [31:0] data_out_q, data_out_d;
   logic        valid_out_q, valid_out_d;
   logic        active_out_q, active_out_d;
   logic        link_up_q, link_up_d;
   logic        overflow_q;

   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_flush;
   logic [31:0]   fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;

   assign ready_out = enable & (fifo_count < CW'(DEPTH));
   assign fifo_push = valid_in & ready_out;

   tx_hold_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk_i   (clk_2f),
      .reset_i (reset),
      .flush_i (fifo_flush),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (data_in),
      .dout_o  (fifo_dout),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case statements can leave a value unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      tcnt_d     = '0;
      wcnt_d     = '0;
      qual_d     = '0;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;

      // Next state. Order inside each state encodes the priority
      // enable=0 > rx_active loss > counters / normal transitions.
      case (state_q)
         ST_DISABLED: begin
            if (enable) state_d = ST_TRAIN;
         end
         ST_TRAIN: begin
            if (!enable)                            state_d = ST_DISABLED;
            else if (tcnt_q == TCW'(TRAIN_WORDS-1)) state_d = ST_WAIT_ACK;
            else                                    tcnt_d  = tcnt_q + 1'b1;
         end
         ST_WAIT_ACK: begin
            if (!enable) begin
               state_d = ST_DISABLED;
            end else if (rx_active && (qual_q == QCW'(RX_QUAL_LEN-1))) begin
               state_d = ST_ACTIVE;
            end else if (wcnt_q == WCW'(TIMEOUT-1)) begin
               state_d = ST_TRAIN;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
               // Qualification restarts on any cycle without rx_active.
               if (rx_active) qual_d = qual_q + 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!enable) begin
               state_d  = ST_DRAIN;
               fifo_pop = rx_active & ~fifo_empty;
            end else if (!rx_active) begin
               // Retrain with the queued words kept for after re-lock.
               state_d = ST_TRAIN;
            end else begin
               fifo_pop = ~fifo_empty;
            end
         end
         ST_DRAIN: begin
            if (!rx_active) begin
               state_d    = ST_DISABLED;
               fifo_flush = 1'b1;
            end else if (fifo_empty) begin
               state_d = ST_DISABLED;
            end else begin
               fifo_pop = 1'b1;
            end
         end
         default: state_d = ST_DISABLED;
      endcase

      // Output registers are loaded from the state being entered, so the
      // datapath signals change on the same edge as state_out.
      data_out_d   = '0;
      valid_out_d  = 1'b0;
      active_out_d = 1'b0;
      link_up_d    = 1'b0;
      case (state_d)
         ST_TRAIN: begin
            data_out_d  = TRAIN_WORD;
            valid_out_d = 1'b1;
         end
         ST_WAIT_ACK: begin
            data_out_d  = IDLE_WORD;
            valid_out_d = 1'b1;
         end
         ST_ACTIVE, ST_DRAIN: begin
            active_out_d = 1'b1;
            link_up_d    = (state_d == ST_ACTIVE);
            data_out_d   = fifo_pop ? fifo_dout : IDLE_WORD;
            valid_out_d  = fifo_pop;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         state_q      <= ST_DISABLED;
         tcnt_q       <= '0;
         wcnt_q       <= '0;
         qual_q       <= '0;
         data_out_q   <= '0;
         valid_out_q  <= 1'b0;
         active_out_q <= 1'b0;
         link_up_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         tcnt_q       <= tcnt_d;
         wcnt_q       <= wcnt_d;
         qual_q       <= qual_d;
         data_out_q   <= data_out_d;
         valid_out_q  <= valid_out_d;
         active_out_q <= active_out_d;
         link_up_q    <= link_up_d;
         // With enable=1, ready_out=0 happens exactly when the FIFO is full.
         overflow_q   <= overflow_q | (valid_in & enable & fifo_full);
      end
   end

   assign data_out     = data_out_q;
   assign valid_out    = valid_out_q;
   assign active_out   = active_out_q;
   assign link_up      = link_up_q;
   assign state_out    = state_q;
   assign overflow_err = overflow_q;

endmodule

// File: doc/phy_tx_link_ctrl.md
Name: phy_tx_link_ctrl

Overview:
Link sequencer in front of the PHY TX datapath (recirculador -> demux_striping -> demux_32_8 -> paralelo_serial), clocked in the clk_2f domain.
- Buffers host words in a small hold FIFO.
- Runs a training/idle preamble, then drives the datapath's data_input/valid/active inputs.
- Stops traffic while the link partner is not locked.
- Drains cleanly on disable.

Parameters:
DEPTH, 4, hold FIFO entries (power of 2, >=2)
TRAIN_WORDS, 4, training words emitted per TRAIN entry
TIMEOUT, 64, WAIT_ACK cycles before retrain
TRAIN_WORD, 32'hBCBCBCBC, training pattern (COM per byte)
IDLE_WORD, 32'h7C7C7C7C, idle pattern (IDL per byte)

Ports:
clk_2f  in  1  clock
reset  in  1  synchronous reset, active-high
enable  in  1  host request to bring link up / keep it up
rx_active  in  1  partner lock indication, already synchronous to clk_2f
data_in  in  32  host word
valid_in  in  1  host word valid
ready_out  out  1  FIFO can accept; push = valid_in & ready_out
data_out  out  32  to datapath data_input
valid_out  out  1  to datapath valid
active_out  out  1  to datapath active
link_up  out  1  high only in ACTIVE
state_out  out  3  current state encoding
overflow_err  out  1  sticky: valid_in seen while ready_out=0

Behaviour:
- Reset (sync, high): state DISABLED; FIFO empty; counters 0; data_out=0, valid_out=0, active_out=0, link_up=0, overflow_err=0. Reset has priority over every other event, including mid-training or mid-drain.
- Output registers: data_out, valid_out, active_out and link_up are registered, updated on each clk_2f edge from current state and FIFO head.
- State encodings: DISABLED=0, TRAIN=1, WAIT_ACK=2, ACTIVE=3, DRAIN=4.
- DISABLED: outputs zero. enable=1 -> TRAIN, with tcnt=0.
- TRAIN:
  - Emits TRAIN_WORD, valid_out=1, active_out=0.
  - tcnt counts 0..TRAIN_WORDS-1; after the last word -> WAIT_ACK, with wcnt=0.
  - enable=0 -> DISABLED immediately.
- WAIT_ACK:
  - Emits IDLE_WORD, valid_out=1, active_out=0.
  - rx_active=1 on 2 consecutive cycles -> ACTIVE.
  - wcnt reaching TIMEOUT-1 -> TRAIN (retrain).
  - enable=0 -> DISABLED.
- ACTIVE:
  - active_out=1, link_up=1.
  - FIFO non-empty: pop one word per cycle; data_out=head, valid_out=1.
  - FIFO empty: data_out=IDLE_WORD, valid_out=0.
  - rx_active=0 -> TRAIN; FIFO contents are preserved and no pop occurs that cycle.
  - enable=0 -> DRAIN.
- DRAIN:
  - Pops as in ACTIVE, active_out=1, link_up=0.
  - FIFO empty -> DISABLED.
  - rx_active=0 -> DISABLED, and the FIFO is flushed.
- FIFO and ready_out:
  - ready_out = enable & (count < DEPTH); combinational from registered count.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count unchanged, data order preserved. This includes the case count==DEPTH-1.
  - Pop from an empty FIFO is never performed.
  - Pushes are allowed in every state where enable=1, so words queue during TRAIN and WAIT_ACK.
- Latency: in ACTIVE with an empty FIFO, a word pushed at edge t is on data_out after edge t+1.
- overflow_err: sets when valid_in=1 & ready_out=0 & enable=1; clears only on reset.
- Priority on a single edge: reset > enable=0 > rx_active loss > counters/normal transitions.

Decomposition:
- Package phy_tx_link_pkg holds:
  - state encodings (3-bit localparams)
  - TRAIN_WORD/IDLE_WORD defaults
  - the rx_active qualification length (2)
- Sub-module tx_hold_fifo (DEPTH x 32, sync, clk_2f, same reset). Interface: push, pop, din, dout, count, full, empty.
- The controller FSM and output registers stay in phy_tx_link_ctrl.

Test Plan:
- Reset check: reset=1 for 2 cycles with enable=1 and valid_in=1 -> all outputs 0, state_out=0, ready_out=1 after reset release.
- Bring-up: enable=1, rx_active=1 from cycle 0.
  - Expect exactly 4 cycles of data_out=BCBCBCBC, valid_out=1.
  - Then 7C7C7C7C for 2 cycles.
  - Then state_out=3, link_up=1, active_out=1.
- Data order and backpressure: in ACTIVE, push 0x11111111..0x66666666 back-to-back with rx_active=1.
  - Outputs appear in order, one per cycle, 1 cycle after each push.
  - No overflow_err.
- Full FIFO / overflow: in WAIT_ACK with rx_active=0, push 5 words.
  - ready_out falls after 4 pushes.
  - The 5th push with ready_out=0 sets overflow_err=1, which stays set.
  - After TIMEOUT=64 cycles, state_out returns to 1.
- Link loss: in ACTIVE with 3 words queued, drop rx_active.
  - Next state_out=1, active_out=0, no pop.
  - After retrain and re-lock, the 3 words emerge in original order.
- Drain: in ACTIVE with 2 queued words, enable=0.
  - state_out=4, both words output with active_out=1.
  - Then state_out=0, valid_out=0, ready_out=0.
